// File: rtl/pes_sysarray_ctrl.sv
// rtl/pes_sysarray_ctrl.sv - tile sequencer for the 8x8 systolic array (SRAM prefetch, alu_start, diagonal output stepping)
module pes_sysarray_ctrl #(
    parameter int ARRAY_SIZE = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int TILE_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  start_i,
    input  logic [TILE_WIDTH-1:0] num_tiles_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_w_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_d_i,
    output logic                  sram_ren_o,
    output logic [ADDR_WIDTH-1:0] sram_raddr_w_o,
    output logic [ADDR_WIDTH-1:0] sram_raddr_d_o,
    output logic                  feed_valid_o,
    output logic                  alu_start_o,
    output logic [8:0]            cycle_num_o,
    output logic [5:0]            matrix_index_o,
    output logic                  out_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // First cycle with a finished result diagonal, and the last array cycle of a tile.
    localparam int FIRST_OUT = ARRAY_SIZE + 1;
    localparam int LAST      = FIRST_OUT + 2 * ARRAY_SIZE - 2;

    localparam logic [8:0]            LAST_C      = 9'(LAST);
    localparam logic [8:0]            FIRST_C     = 9'(FIRST_OUT);
    localparam logic [8:0]            FEED_C      = 9'(ARRAY_SIZE);
    localparam logic [8:0]            READ_LAST_C = 9'(ARRAY_SIZE - 2);
    localparam logic [ADDR_WIDTH-1:0] STRIDE      = ADDR_WIDTH'(ARRAY_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ONE_A       = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_RUN,
        S_FIN
    } state_t;

    state_t                state_q;
    logic [8:0]            cyc_q;
    logic [TILE_WIDTH-1:0] tiles_left_q;
    logic [ADDR_WIDTH-1:0] base_w_q;
    logic [ADDR_WIDTH-1:0] base_d_q;

    logic                  sram_ren_q;
    logic [ADDR_WIDTH-1:0] raddr_w_q;
    logic [ADDR_WIDTH-1:0] raddr_d_q;
    logic                  feed_valid_q;
    logic                  alu_start_q;
    logic [8:0]            cycle_num_q;
    logic [5:0]            matrix_index_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic                  done_q;

    // Values for the following RUN cycle; word k is requested one cycle before c==k.
    logic [8:0]            cyc_d;
    logic [TILE_WIDTH-1:0] tiles_left_d;
    logic [ADDR_WIDTH-1:0] next_base_w_d;
    logic [ADDR_WIDTH-1:0] next_base_d_d;
    logic [ADDR_WIDTH-1:0] rd_off_d;
    logic                  rd_en_d;
    logic                  ov_d;

    assign cyc_d         = cyc_q + 9'd1;
    assign tiles_left_d  = tiles_left_q - TILE_WIDTH'(1);
    assign next_base_w_d = base_w_q + STRIDE;
    assign next_base_d_d = base_d_q + STRIDE;
    assign rd_off_d      = ADDR_WIDTH'(cyc_d) + ONE_A;
    assign rd_en_d       = (cyc_d <= READ_LAST_C);
    assign ov_d          = (cyc_d >= FIRST_C);

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q        <= S_IDLE;
            cyc_q          <= '0;
            tiles_left_q   <= '0;
            base_w_q       <= '0;
            base_d_q       <= '0;
            sram_ren_q     <= 1'b0;
            raddr_w_q      <= '0;
            raddr_d_q      <= '0;
            feed_valid_q   <= 1'b0;
            alu_start_q    <= 1'b0;
            cycle_num_q    <= '0;
            matrix_index_q <= '0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (num_tiles_i != '0) begin
                            state_q      <= S_PRE;
                            tiles_left_q <= num_tiles_i;
                            base_w_q     <= base_addr_w_i;
                            base_d_q     <= base_addr_d_i;
                            busy_q       <= 1'b1;
                            sram_ren_q   <= 1'b1;
                            raddr_w_q    <= base_addr_w_i;
                            raddr_d_q    <= base_addr_d_i;
                        end else begin
                            // Empty job: acknowledge immediately without touching SRAM.
                            done_q <= 1'b1;
                        end
                    end
                end
                S_PRE: begin
                    state_q        <= S_RUN;
                    cyc_q          <= '0;
                    alu_start_q    <= 1'b1;
                    cycle_num_q    <= '0;
                    feed_valid_q   <= 1'b1;
                    sram_ren_q     <= 1'b1;
                    raddr_w_q      <= base_w_q + ONE_A;
                    raddr_d_q      <= base_d_q + ONE_A;
                    out_valid_q    <= 1'b0;
                    matrix_index_q <= '0;
                end
                S_RUN: begin
                    if (cyc_q == LAST_C) begin
                        cyc_q          <= '0;
                        alu_start_q    <= 1'b0;
                        cycle_num_q    <= '0;
                        feed_valid_q   <= 1'b0;
                        out_valid_q    <= 1'b0;
                        matrix_index_q <= '0;
                        tiles_left_q   <= tiles_left_d;
                        if (tiles_left_d != '0) begin
                            // Next tile: bases step by one array width and wrap silently.
                            state_q    <= S_PRE;
                            base_w_q   <= next_base_w_d;
                            base_d_q   <= next_base_d_d;
                            sram_ren_q <= 1'b1;
                            raddr_w_q  <= next_base_w_d;
                            raddr_d_q  <= next_base_d_d;
                        end else begin
                            state_q    <= S_FIN;
                            done_q     <= 1'b1;
                            sram_ren_q <= 1'b0;
                            raddr_w_q  <= '0;
                            raddr_d_q  <= '0;
                        end
                    end else begin
                        cyc_q          <= cyc_d;
                        cycle_num_q    <= cyc_d;
                        sram_ren_q     <= rd_en_d;
                        raddr_w_q      <= rd_en_d ? (base_w_q + rd_off_d) : '0;
                        raddr_d_q      <= rd_en_d ? (base_d_q + rd_off_d) : '0;
                        feed_valid_q   <= (cyc_d < FEED_C);
                        out_valid_q    <= ov_d;
                        matrix_index_q <= ov_d ? 6'(cyc_d - FIRST_C) : '0;
                    end
                end
                S_FIN: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    tiles_left_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sram_ren_o     = sram_ren_q;
    assign sram_raddr_w_o = raddr_w_q;
    assign sram_raddr_d_o = raddr_d_q;
    assign feed_valid_o   = feed_valid_q;
    assign alu_start_o    = alu_start_q;
    assign cycle_num_o    = cycle_num_q;
    assign matrix_index_o = matrix_index_q;
    assign out_valid_o    = out_valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_pes_sysarray_ctrl.sv
// tb/tb_pes_sysarray_ctrl.sv - scoreboard bench for pes_sysarray_ctrl with a timeline reference model
module tb_pes_sysarray_ctrl;

    localparam int AS   = 8;
    localparam int AW   = 10;
    localparam int TW   = 6;
    localparam int LAST = 3 * AS - 1;
    localparam int TILE = LAST + 2;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          srst;
    logic          start;
    logic [TW-1:0] nt;
    logic [AW-1:0] bw;
    logic [AW-1:0] bd;
    logic          sram_ren;
    logic [AW-1:0] raddr_w;
    logic [AW-1:0] raddr_d;
    logic          feed_valid;
    logic          alu_start;
    logic [8:0]    cycle_num;
    logic [5:0]    matrix_index;
    logic          out_valid;
    logic          busy;
    logic          done;

    pes_sysarray_ctrl #(.ARRAY_SIZE(AS), .ADDR_WIDTH(AW), .TILE_WIDTH(TW)) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .start_i        (start),
        .num_tiles_i    (nt),
        .base_addr_w_i  (bw),
        .base_addr_d_i  (bd),
        .sram_ren_o     (sram_ren),
        .sram_raddr_w_o (raddr_w),
        .sram_raddr_d_o (raddr_d),
        .feed_valid_o   (feed_valid),
        .alu_start_o    (alu_start),
        .cycle_num_o    (cycle_num),
        .matrix_index_o (matrix_index),
        .out_valid_o    (out_valid),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t rd_q[$];
    ev_t run_q[$];
    ev_t out_q[$];
    int  done_q[$];
    int  busy_from = -1;
    int  busy_to   = -1;
    int  idle_from = 0;
    bit  mon_en    = 1'b0;

    function automatic ev_t mk(int c, int a, int b);
        ev_t e;
        e.cyc = c;
        e.a   = a;
        e.b   = b;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference timeline: a job started in cycle s occupies cycle s+1 with the
    // prefetch, then LAST+1 array cycles per tile, done after the last tile.
    task automatic model_start(int s, int n, int w, int d);
        if (s < idle_from) return;
        if (n == 0) begin
            done_q.push_back(s + 1);
            return;
        end
        for (int t = 0; t < n; t++) begin
            int p;
            int wb;
            int db;
            p  = s + 1 + TILE * t;
            wb = (w + AS * t) % AMOD;
            db = (d + AS * t) % AMOD;
            rd_q.push_back(mk(p, wb, db));
            for (int c = 0; c <= LAST; c++) begin
                if (c <= AS - 2) rd_q.push_back(mk(p + 1 + c, (wb + c + 1) % AMOD, (db + c + 1) % AMOD));
                run_q.push_back(mk(p + 1 + c, c, (c < AS) ? 1 : 0));
                if (c >= AS + 1) out_q.push_back(mk(p + 1 + c, c - AS - 1, 0));
            end
        end
        done_q.push_back(s + 1 + TILE * n);
        busy_from = s + 1;
        busy_to   = s + 1 + TILE * n;
        idle_from = busy_to + 1;
    endtask

    // Monitor: pop the expected event whenever the DUT presents one.
    always @(negedge clk) begin : monitor
        ev_t e;
        int  dc;
        if (mon_en) begin
            check("busy", busy, (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
            if (sram_ren) begin
                if (rd_q.size() == 0) check("unexpected_read", 1, 0);
                else begin
                    e = rd_q.pop_front();
                    check("read_cycle", cyc, e.cyc);
                    check("raddr_w", raddr_w, e.a);
                    check("raddr_d", raddr_d, e.b);
                end
            end
            if (alu_start) begin
                if (run_q.size() == 0) check("unexpected_alu_start", 1, 0);
                else begin
                    e = run_q.pop_front();
                    check("run_cycle", cyc, e.cyc);
                    check("cycle_num", cycle_num, e.a);
                    check("feed_valid", feed_valid, e.b);
                end
            end else begin
                check("feed_valid_idle", feed_valid, 0);
            end
            if (out_valid) begin
                if (out_q.size() == 0) check("unexpected_out_valid", 1, 0);
                else begin
                    e = out_q.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("matrix_index", matrix_index, e.a);
                end
            end else begin
                check("matrix_index_idle", matrix_index, 0);
            end
            if (done) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    dc = done_q.pop_front();
                    check("done_cycle", cyc, dc);
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(int n, int w, int d);
        start = 1'b1;
        nt    = TW'(n);
        bw    = AW'(w);
        bd    = AW'(d);
        model_start(cyc, n, w, d);
        step(1);
        start = 1'b0;
        nt    = $urandom_range(0, 63);
        bw    = $urandom_range(0, AMOD - 1);
        bd    = $urandom_range(0, AMOD - 1);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (cyc <= idle_from && guard < 5000) begin
            step(1);
            guard++;
        end
        step(2);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_sram_ren"}, sram_ren, 0);
        check({tag, "_raddr_w"}, raddr_w, 0);
        check({tag, "_raddr_d"}, raddr_d, 0);
        check({tag, "_alu_start"}, alu_start, 0);
        check({tag, "_cycle_num"}, cycle_num, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int s;
        srst  = 1'b1;
        start = 1'b0;
        nt    = '0;
        bw    = '0;
        bd    = '0;
        step(3);
        srst      = 1'b0;
        idle_from = cyc;
        mon_en    = 1'b1;
        step(10);
        check_zero("reset");

        // Single tile with the reference bases.
        issue(1, 'h000, 'h100);
        wait_idle();

        // Three tiles, with a start pulse during RUN that must be ignored.
        issue(3, 'h000, 'h100);
        step(10);
        issue(2, 'h055, 'h066);
        wait_idle();

        // Empty job: single done pulse, no reads.
        issue(0, 'h123, 'h045);
        wait_idle();

        // Reset at c=12 of tile 2, then a fresh job.
        s = cyc;
        issue(3, 'h040, 'h200);
        step(s + 1 + TILE + 1 + 12 - cyc);
        check("srst_point_cycle_num", cycle_num, 12);
        srst = 1'b1;
        step(1);
        srst = 1'b0;
        rd_q.delete();
        run_q.delete();
        out_q.delete();
        done_q.delete();
        busy_from = -1;
        busy_to   = -1;
        idle_from = cyc;
        check_zero("after_srst");
        issue(1, 'h010, 'h020);
        wait_idle();

        // Address wrap at the top of the weight SRAM.
        issue(2, 'h3FC, 'h3FE);
        wait_idle();

        // Random jobs, some issued while the sequencer is still busy.
        for (int i = 0; i < 30; i++) begin
            issue($urandom_range(0, 3), $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1));
            step($urandom_range(0, 90));
        end
        wait_idle();

        check("rd_q_left", rd_q.size(), 0);
        check("run_q_left", run_q.size(), 0);
        check("out_q_left", out_q.size(), 0);
        check("done_q_left", done_q.size(), 0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
